// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_rd_pkg;

  localparam int unsigned DEF_DSIZE = 8;
  localparam int unsigned DEF_PACK  = 4;
  localparam int unsigned MAX_PACK  = 32;

  // Beat layout for the default DSIZE/PACK configuration.
  typedef struct packed {
    logic [DEF_DSIZE*DEF_PACK-1:0] data;
    logic [DEF_PACK-1:0]           keep;
    logic                          partial;
  } beat_t;

  // Lane mask with the low 'count' lanes set, capped at 'pack' lanes.
  function automatic logic [MAX_PACK-1:0] keep_mask(input int unsigned count,
                                                    input int unsigned pack);
    logic [MAX_PACK-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_PACK; i++) begin
      if (i < count && i < pack) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_beat_reg.sv
// One-entry valid/ready holding register for an output beat.
module fifo_beat_reg #(
  parameter type beat_t = fifo_rd_pkg::beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  ready,
  input  beat_t d,
  output logic  valid,
  output beat_t q,
  output logic  free
);

  assign free = !valid || ready;

  // Capture a new beat on load; otherwise drop valid once it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops words from the async FIFO read port and packs PACK of them into one
// valid/ready beat; a flush request emits a partially filled beat.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned PACK  = 4
) (
  input  logic                  r_clk,
  input  logic                  rstn,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DSIZE*PACK-1:0] m_data,
  output logic [PACK-1:0]       m_keep,
  output logic                  m_partial
);

  localparam int unsigned CNT_W = $clog2(PACK + 1);

  typedef struct packed {
    logic [DSIZE*PACK-1:0] data;
    logic [PACK-1:0]       keep;
    logic                  partial;
  } lbeat_t;

  typedef enum logic {FL_IDLE, FL_BUSY} fl_state_t;

  fl_state_t                   fl_state, fl_state_nxt;
  logic                        run;
  logic [CNT_W-1:0]            count, count_nxt, lane_idx;
  logic [PACK-1:0][DSIZE-1:0]  asm_q;
  logic                        free, move, full, nonzero;
  logic [MAX_PACK-1:0]         keep_wide;
  lbeat_t                      beat_d, beat_q;

  assign full       = (count == CNT_W'(PACK));
  assign nonzero    = (count != '0);
  assign flush_busy = (fl_state == FL_BUSY);
  assign move       = free && (full || (flush_busy && nonzero));
  assign rinc       = run && !rempty && !flush_busy && (!full || move);
  // A pop that coincides with a move restarts the beat at lane 0.
  assign lane_idx   = move ? '0 : count;

  // Run flag: rises on the first edge after reset release to gate pops.
  always_ff @(posedge r_clk or negedge rstn) begin
    if (!rstn) run <= 1'b0;
    else       run <= 1'b1;
  end

  // Next fill count: reset on move (plus the coinciding pop), else count pops.
  always_comb begin
    count_nxt = count;
    if (move)      count_nxt = rinc ? CNT_W'(1) : '0;
    else if (rinc) count_nxt = count + CNT_W'(1);
  end

  // Fill counter and assembly lanes.
  always_ff @(posedge r_clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      asm_q <= '0;
    end else begin
      count <= count_nxt;
      for (int unsigned i = 0; i < PACK; i++) begin
        if (rinc && lane_idx == CNT_W'(i)) asm_q[i] <= rdata;
      end
    end
  end

  // Beat candidate: unfilled lanes are forced to zero.
  always_comb begin
    keep_wide      = keep_mask(int'(count), PACK);
    beat_d         = '0;
    beat_d.keep    = keep_wide[PACK-1:0];
    beat_d.partial = !full;
    for (int unsigned i = 0; i < PACK; i++) begin
      beat_d.data[i*DSIZE +: DSIZE] = keep_wide[i] ? asm_q[i] : '0;
    end
  end

  // Flush state register.
  always_ff @(posedge r_clk or negedge rstn) begin
    if (!rstn) fl_state <= FL_IDLE;
    else       fl_state <= fl_state_nxt;
  end

  // Flush next-state: accept in idle, finish on the move or when nothing is held.
  always_comb begin
    fl_state_nxt = fl_state;
    case (fl_state)
      FL_IDLE: if (flush) fl_state_nxt = FL_BUSY;
      FL_BUSY: if (move || !nonzero) fl_state_nxt = FL_IDLE;
      default: fl_state_nxt = FL_IDLE;
    endcase
  end

  fifo_beat_reg #(.beat_t(lbeat_t)) u_beat_reg (
    .clk   (r_clk),
    .rst_n (rstn),
    .load  (move),
    .ready (m_ready),
    .d     (beat_d),
    .valid (m_valid),
    .q     (beat_q),
    .free  (free)
  );

  assign m_data    = beat_q.data;
  assign m_keep    = beat_q.keep;
  assign m_partial = beat_q.partial;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a queue-backed FIFO model.
module tb_fifo_rd_packer;

  logic        r_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        rempty, rinc, flush_busy, m_valid, m_partial;
  logic [7:0]  rdata;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        partial;
  } exp_t;

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         beats_seen = 0;
  logic       pop_seen;

  always #5 r_clk = ~r_clk;

  fifo_rd_packer #(.DSIZE(8), .PACK(4)) dut (
    .r_clk      (r_clk),
    .rstn       (rstn),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .flush      (flush),
    .flush_busy (flush_busy),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_partial  (m_partial)
  );

  assign rempty = (fifo_q.size() == 0);
  assign rdata  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];

  // FIFO model: a word is consumed on each edge where rinc was high.
  always @(posedge r_clk) begin
    pop_seen = rinc;
    #1;
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
  end

  // Scoreboard: compare each accepted beat against the oldest expectation.
  always @(negedge r_clk) begin
    if (rstn && m_valid && m_ready) begin
      exp_t e;
      beats_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h keep=%h partial=%b, required no beat",
                 m_data, m_keep, m_partial);
      end else begin
        e = exp_q.pop_front();
        if ({m_data, m_keep, m_partial} !== e) begin
          errors++;
          $display("FAIL beat: got data=%h keep=%h partial=%b, required data=%h keep=%h partial=%b",
                   m_data, m_keep, m_partial, e.data, e.keep, e.partial);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic p);
    exp_t e;
    e.data = d; e.keep = k; e.partial = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge r_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m_ready = 1'b1;
    push_exp(32'h04030201, 4'hF, 1'b0);
    for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i));
    repeat (3) tick();
    @(negedge r_clk);
    checks++;
    if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b, required 0", rinc); end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", m_valid); end
    checks++;
    if (m_keep !== 4'h0) begin errors++; $display("FAIL reset_keep: got %h, required 0", m_keep); end
    tick();
    rstn = 1'b1;
    @(negedge r_clk);
    checks++;
    if (rinc !== 1'b0) begin errors++; $display("FAIL first_edge_rinc: got %b, required 0", rinc); end
    tick();
    checks++;
    if (rinc !== 1'b1) begin errors++; $display("FAIL second_edge_rinc: got %b, required 1", rinc); end
    wait_drain("reset");
  endtask

  task automatic test_streaming();
    int total = 0, cur = 0, maxr = 0;
    m_ready = 1'b1;
    tick();
    push_exp(32'h44332211, 4'hF, 1'b0);
    push_exp(32'h88776655, 4'hF, 1'b0);
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(8'h11 * i));
    for (int c = 0; c < 20; c++) begin
      @(negedge r_clk);
      if (rinc) begin
        total++; cur++;
        if (cur > maxr) maxr = cur;
      end else cur = 0;
    end
    checks++;
    if (total != 8) begin errors++; $display("FAIL stream_pops: got %0d, required 8", total); end
    checks++;
    if (maxr != 8) begin errors++; $display("FAIL stream_run: got %0d consecutive, required 8", maxr); end
    wait_drain("stream");
  endtask

  task automatic test_backpressure();
    int pops = 0, unstable = 0;
    logic have = 1'b0;
    logic [31:0] held = '0;
    tick();
    m_ready = 1'b0;
    push_exp(32'h24232221, 4'hF, 1'b0);
    push_exp(32'h28272625, 4'hF, 1'b0);
    push_exp(32'h2C2B2A29, 4'hF, 1'b0);
    for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h21 + i));
    for (int c = 0; c < 10; c++) begin
      @(negedge r_clk);
      if (rinc) pops++;
      if (m_valid) begin
        if (!have) begin held = m_data; have = 1'b1; end
        else if (m_data !== held) unstable++;
      end
    end
    checks++;
    if (pops != 8) begin errors++; $display("FAIL bp_pops: got %0d, required 8", pops); end
    checks++;
    if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc_stall: got %b, required 0", rinc); end
    checks++;
    if (held !== 32'h24232221) begin errors++; $display("FAIL bp_held: got %h, required 24232221", held); end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes, required 0", unstable); end
    tick();
    m_ready = 1'b1;
    #1;
    checks++;
    if (rinc !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b, required 1", rinc); end
    wait_drain("backpressure");
  endtask

  task automatic test_flush_partial();
    m_ready = 1'b1;
    tick();
    push_exp(32'h00C3B2A1, 4'h7, 1'b1);
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hB2);
    fifo_q.push_back(8'hC3);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge r_clk);
    checks++;
    if (flush_busy !== 1'b1) begin errors++; $display("FAIL fp_busy_set: got %b, required 1", flush_busy); end
    tick();
    @(negedge r_clk);
    checks++;
    if (flush_busy !== 1'b0) begin errors++; $display("FAIL fp_busy_clear: got %b, required 0", flush_busy); end
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL fp_valid: got %b, required 1", m_valid); end
    wait_drain("flush_partial");
  endtask

  task automatic test_flush_empty();
    int b0;
    tick();
    b0 = beats_seen;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge r_clk);
    checks++;
    if (flush_busy !== 1'b1) begin errors++; $display("FAIL fe_busy_set: got %b, required 1", flush_busy); end
    tick();
    @(negedge r_clk);
    checks++;
    if (flush_busy !== 1'b0) begin errors++; $display("FAIL fe_busy_clear: got %b, required 0", flush_busy); end
    repeat (4) tick();
    checks++;
    if (beats_seen != b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL fe_no_beat: got %0d beats valid=%b, required 0 beats valid=0", beats_seen - b0, m_valid);
    end
  endtask

  task automatic test_flush_full();
    m_ready = 1'b0;
    tick();
    push_exp(32'h34333231, 4'hF, 1'b0);
    push_exp(32'h38373635, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h31 + i));
    repeat (12) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge r_clk);
    checks++;
    if (flush_busy !== 1'b1 || rinc !== 1'b0) begin
      errors++;
      $display("FAIL ff_busy: got busy=%b rinc=%b, required busy=1 rinc=0", flush_busy, rinc);
    end
    tick();
    m_ready = 1'b1;
    tick();
    @(negedge r_clk);
    checks++;
    if (flush_busy !== 1'b0) begin errors++; $display("FAIL ff_busy_clear: got %b, required 0", flush_busy); end
    wait_drain("flush_full");
  endtask

  task automatic test_reset_mid();
    int b0;
    m_ready = 1'b1;
    tick();
    b0 = beats_seen;
    fifo_q.push_back(8'h51);
    fifo_q.push_back(8'h52);
    repeat (4) tick();
    rstn = 1'b0;
    @(negedge r_clk);
    checks++;
    if (m_valid !== 1'b0 || m_keep !== 4'h0) begin
      errors++;
      $display("FAIL rm_in_reset: got valid=%b keep=%h, required valid=0 keep=0", m_valid, m_keep);
    end
    repeat (2) tick();
    rstn = 1'b1;
    repeat (6) tick();
    checks++;
    if (beats_seen != b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_beat: got %0d beats valid=%b, required 0 beats valid=0", beats_seen - b0, m_valid);
    end
    push_exp(32'h64636261, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h61 + i));
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
